// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue block.
// Contents: RV32I opcode constants, alu_mode encodings, issue FSM state enum,
//           and decode helpers for legality and ALU mode selection.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WB    = 2'd2
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   // alu_mode = {alt, funct3}; alt selects SUB / SRA.
   localparam logic [3:0] MODE_ADD     = 4'b0000;
   localparam logic [3:0] MODE_SUB     = 4'b1000;
   localparam logic [3:0] MODE_SLL     = 4'b0001;
   localparam logic [3:0] MODE_SLT     = 4'b0010;
   localparam logic [3:0] MODE_SLTU    = 4'b0011;
   localparam logic [3:0] MODE_XOR     = 4'b0100;
   localparam logic [3:0] MODE_SRL     = 4'b0101;
   localparam logic [3:0] MODE_SRA     = 4'b1101;
   localparam logic [3:0] MODE_OR      = 4'b0110;
   localparam logic [3:0] MODE_AND     = 4'b0111;
   localparam logic [3:0] MODE_ILLEGAL = 4'b1111;

   // Only the OP / OP-IMM encodings the ALU can execute are legal.
   function automatic logic is_legal(input logic [31:0] instr);
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      opcode = instr[6:0];
      funct3 = instr[14:12];
      funct7 = instr[31:25];
      is_legal = 1'b0;
      if (opcode == OPC_OP) begin
         is_legal = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end else if (opcode == OPC_OP_IMM) begin
         case (funct3)
            3'b001:  is_legal = (funct7 == 7'b0000000);
            3'b101:  is_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            default: is_legal = 1'b1;
         endcase
      end
   endfunction

   // For OP-IMM, instr[30] is an immediate bit except for shifts-right,
   // so it only contributes to the mode when funct3 selects SRLI/SRAI.
   function automatic logic [3:0] decode_mode(input logic [31:0] instr);
      if (instr[6:0] == OPC_OP || instr[14:12] == 3'b101)
         decode_mode = {instr[30], instr[14:12]};
      else
         decode_mode = {1'b0, instr[14:12]};
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32x32 integer register file with x0 hardwired to zero.
// Ports: clk, reset (async, active-high; clears x1..x31 when RF_CLEAR=1),
//        we/waddr/wdata (synchronous write), raddr_a/rdata_a and
//        raddr_b/rdata_b (combinational reads), dbg_addr/dbg_data
//        (combinational debug read).
module alu_regfile #(
   parameter bit RF_CLEAR = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr_a,
   output logic [31:0] rdata_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_b,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   logic [31:0] mem [0:31];

   // NOTE: the storage only gets a reset branch when clearing is wanted; a
   // memory without reset maps onto plain RAM cells, one with reset cannot.
   generate
      if (RF_CLEAR) begin : g_clear
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < 32; i++) mem[i] <= '0;
            end else if (we && waddr != 5'd0) begin
               mem[waddr] <= wdata;
            end
         end
      end else begin : g_keep
         always_ff @(posedge clk) begin
            if (we && waddr != 5'd0) mem[waddr] <= wdata;
         end
      end
   endgenerate

   // x0 is decoded away on read, so mem[0] is never observed.
   assign rdata_a  = (raddr_a  == 5'd0) ? '0 : mem[raddr_a];
   assign rdata_b  = (raddr_b  == 5'd0) ? '0 : mem[raddr_b];
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Single-issue front end for an external ALU: decodes RV32I OP/OP-IMM
// instructions, reads operands, presents them to the ALU, and writes the
// ALU result back. One instruction every 3 cycles (IDLE -> ISSUE -> WB).
// Ports: clk, reset (async, active-high), instr_valid/instr/instr_ready
//        (instruction handshake), alu_rs1/alu_rs2/alu_mode (registered ALU
//        request), alu_rd (ALU result), retire/retire_rd/retire_data
//        (writeback report), illegal (dropped-instruction pulse),
//        dbg_addr/dbg_data (register-file debug read).
module alu_issue
   import alu_pkg::*;
#(
   parameter bit RF_CLEAR = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   output logic [31:0] alu_rs1,
   output logic [31:0] alu_rs2,
   output logic [3:0]  alu_mode,
   input  logic [31:0] alu_rd,
   output logic        retire,
   output logic [4:0]  retire_rd,
   output logic [31:0] retire_data,
   output logic        illegal,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   state_t      state;
   logic [4:0]  wb_rd;
   logic [31:0] rf_rs1;
   logic [31:0] rf_rs2;
   logic [31:0] imm_i;

   // Operands are read straight from the incoming word; the previous write
   // lands on the WB->IDLE edge, a full cycle before the earliest next
   // acceptance edge, so no bypass is needed.
   alu_regfile #(.RF_CLEAR(RF_CLEAR)) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .we       (state == WB),
      .waddr    (wb_rd),
      .wdata    (alu_rd),
      .raddr_a  (instr[19:15]),
      .rdata_a  (rf_rs1),
      .raddr_b  (instr[24:20]),
      .rdata_b  (rf_rs2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   assign imm_i       = {{20{instr[31]}}, instr[31:20]};
   assign instr_ready = (state == IDLE);

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         alu_rs1     <= '0;
         alu_rs2     <= '0;
         alu_mode    <= '0;
         wb_rd       <= '0;
         retire      <= 1'b0;
         retire_rd   <= '0;
         retire_data <= '0;
         illegal     <= 1'b0;
      end else begin
         retire  <= 1'b0;
         illegal <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  if (is_legal(instr)) begin
                     alu_rs1  <= rf_rs1;
                     alu_rs2  <= (instr[6:0] == OPC_OP) ? rf_rs2 : imm_i;
                     alu_mode <= decode_mode(instr);
                     wb_rd    <= instr[11:7];
                     state    <= ISSUE;
                  end else begin
                     // Dropped: operands keep their last value.
                     alu_mode <= MODE_ILLEGAL;
                     illegal  <= 1'b1;
                  end
               end
            end
            ISSUE: state <= WB;
            WB: begin
               retire      <= 1'b1;
               retire_rd   <= wb_rd;
               retire_data <= alu_rd;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized
// OP/OP-IMM traffic. A reference model computes each instruction's effect
// from RV32I semantics; expected retire/illegal events go into a scoreboard
// queue that a separate monitor drains whenever the DUT reports an event.
module tb_alu_issue;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [31:0] alu_rs1;
   logic [31:0] alu_rs2;
   logic [3:0]  alu_mode;
   logic [31:0] alu_rd;
   logic        retire;
   logic [4:0]  retire_rd;
   logic [31:0] retire_data;
   logic        illegal;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   alu_issue #(.RF_CLEAR(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .alu_rs1     (alu_rs1),
      .alu_rs2     (alu_rs2),
      .alu_mode    (alu_mode),
      .alu_rd      (alu_rd),
      .retire      (retire),
      .retire_rd   (retire_rd),
      .retire_data (retire_data),
      .illegal     (illegal),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- external ALU stub: result one cycle after operands
   function automatic logic [31:0] alu_stub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] m);
      case (m)
         4'b0000: alu_stub = a + b;
         4'b1000: alu_stub = a - b;
         4'b0001: alu_stub = a << b[4:0];
         4'b0010: alu_stub = {31'd0, $signed(a) < $signed(b)};
         4'b0011: alu_stub = {31'd0, a < b};
         4'b0100: alu_stub = a ^ b;
         4'b0101: alu_stub = a >> b[4:0];
         4'b1101: alu_stub = $signed(a) >>> b[4:0];
         4'b0110: alu_stub = a | b;
         4'b0111: alu_stub = a & b;
         default: alu_stub = 32'hDEAD_BEEF;
      endcase
   endfunction

   always @(posedge clk) alu_rd <= alu_stub(alu_rs1, alu_rs2, alu_mode);

   // ---------------- reference model
   logic [31:0] ref_rf [32];
   logic [31:0] last_a, last_b;

   function automatic void ref_exec(input logic [31:0] ins, output bit legal,
                                    output logic [31:0] a, output logic [31:0] b,
                                    output logic [31:0] res);
      logic [6:0] op;
      logic [6:0] f7;
      logic [2:0] f3;
      logic [4:0] sh;
      op = ins[6:0];
      f7 = ins[31:25];
      f3 = ins[14:12];
      a  = ref_rf[ins[19:15]];
      if (op == 7'b0110011) begin
         b     = ref_rf[ins[24:20]];
         legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end else if (op == 7'b0010011) begin
         b = {{20{ins[31]}}, ins[31:20]};
         if (f3 == 3'd1)      legal = (f7 == 7'h00);
         else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
         else                 legal = 1'b1;
      end else begin
         b     = '0;
         legal = 1'b0;
      end
      sh = b[4:0];
      case (f3)
         3'd0:    res = (op == 7'b0110011 && f7 == 7'h20) ? a - b : a + b;
         3'd1:    res = a << sh;
         3'd2:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    res = (a < b) ? 32'd1 : 32'd0;
         3'd4:    res = a ^ b;
         3'd5:    res = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
         3'd6:    res = a | b;
         default: res = a & b;
      endcase
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   // ---------------- scoreboard + monitor
   typedef struct {
      bit          ill;
      logic [4:0]  rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];

   always @(negedge clk) begin
      if (!reset && (retire || illegal)) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_event", {30'd0, retire, illegal}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_illegal", {31'd0, illegal}, {31'd0, e.ill});
            check("sb_retire", {31'd0, retire}, {31'd0, !e.ill});
            if (!e.ill) begin
               check("sb_retire_rd", {27'd0, retire_rd}, {27'd0, e.rd});
               check("sb_retire_data", retire_data, e.data);
            end
            check("sb_latency", cyc - e.cyc, e.ill ? 32'd1 : 32'd3);
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge)
   task automatic chk_dbg(input logic [4:0] r);
      dbg_addr = r;
      #1;
      check($sformatf("dbg_x%0d", r), dbg_data, ref_rf[r]);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) check("ready_timeout", {31'd0, instr_ready}, 32'd1);
   endtask

   task automatic issue(input logic [31:0] ins, input bit chk_mode, input logic [3:0] exp_mode);
      bit          legal;
      logic [31:0] a, b, res;
      exp_t        e;
      int          n;
      wait_ready();
      ref_exec(ins, legal, a, b, res);
      e.ill  = !legal;
      e.rd   = ins[11:7];
      e.data = res;
      e.cyc  = cyc;
      sb_q.push_back(e);
      instr       = ins;
      instr_valid = 1'b1;
      @(negedge clk);
      if (legal) begin
         check("issue_rs1", alu_rs1, a);
         check("issue_rs2", alu_rs2, b);
         check("issue_ready_low", {31'd0, instr_ready}, 32'd0);
         if (chk_mode) check("issue_mode", {28'd0, alu_mode}, {28'd0, exp_mode});
         last_a = a;
         last_b = b;
         if (ins[11:7] != 5'd0) ref_rf[ins[11:7]] = res;
      end else begin
         check("illegal_mode", {28'd0, alu_mode}, 32'hF);
         check("illegal_rs1_kept", alu_rs1, last_a);
         check("illegal_rs2_kept", alu_rs2, last_b);
         check("illegal_ready_next", {31'd0, instr_ready}, 32'd1);
      end
      // Keep offering junk while busy; it must be ignored.
      n = 0;
      while (!instr_ready && n < 20) begin
         instr = $urandom;
         @(negedge clk);
         n++;
      end
      instr_valid = 1'b0;
   endtask

   task automatic clear_ref();
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
      last_a = '0;
      last_b = '0;
   endtask

   // ---------------- main sequence
   initial begin
      logic [31:0] ins;
      logic [6:0]  f7;
      int          n;
      clear_ref();
      instr_valid = 1'b0;
      instr       = '0;
      dbg_addr    = '0;
      reset       = 1'b1;
      #1;
      check("rst_alu_rs1", alu_rs1, 32'd0);
      check("rst_alu_rs2", alu_rs2, 32'd0);
      check("rst_alu_mode", {28'd0, alu_mode}, 32'd0);
      check("rst_retire", {31'd0, retire}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'd0, instr_ready}, 32'd1);

      // ADDI x1,x0,5
      issue(32'h0050_0093, 1'b1, 4'b0000);
      chk_dbg(5'd1);
      // ADDI x2,x0,-3 ; SUB x3,x1,x2
      issue(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 1'b1, 4'b0000);
      issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1, 4'b1000);
      chk_dbg(5'd3);
      // SRAI x4,x2,1 ; SRLI x4,x2,1
      issue(32'h4011_5213, 1'b1, 4'b1101);
      chk_dbg(5'd4);
      issue(enc_i(12'h001, 5'd2, 3'd5, 5'd4), 1'b1, 4'b0101);
      chk_dbg(5'd4);
      // JAL: dropped
      issue(32'h0000_006F, 1'b0, 4'b0000);
      for (int r = 0; r < 5; r++) chk_dbg(5'(r));
      // ADDI x0,x0,7: retires, x0 stays zero
      issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0), 1'b0, 4'b0000);
      chk_dbg(5'd0);

      // Randomized OP/OP-IMM traffic on x0..x7 with some illegal encodings.
      for (int k = 0; k < 150; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: f7 = 7'h00;
            6, 7, 8:          f7 = 7'h20;
            default:          f7 = 7'($urandom);
         endcase
         if ($urandom_range(0, 1) == 0)
            ins = enc_r(f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        3'($urandom), 5'($urandom_range(0, 7)));
         else
            ins = enc_i({f7, 5'($urandom)}, 5'($urandom_range(0, 7)),
                        3'($urandom), 5'($urandom_range(0, 7)));
         if ($urandom_range(0, 11) == 0) ins[6:0] = 7'($urandom);
         issue(ins, 1'b0, 4'b0000);
         n = $urandom_range(0, 2);
         repeat (n) @(negedge clk);
         if (k % 10 == 9) chk_dbg(5'($urandom_range(0, 7)));
      end
      for (int r = 0; r < 8; r++) chk_dbg(5'(r));

      // Reset during WB of ADDI x5,x0,9: no retire, no write.
      wait_ready();
      instr       = enc_i(12'd9, 5'd0, 3'd0, 5'd5);
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("wbrst_retire", {31'd0, retire}, 32'd0);
      check("wbrst_alu_rs1", alu_rs1, 32'd0);
      check("wbrst_alu_rs2", alu_rs2, 32'd0);
      check("wbrst_alu_mode", {28'd0, alu_mode}, 32'd0);
      check("wbrst_retire_rd", {27'd0, retire_rd}, 32'd0);
      check("wbrst_retire_data", retire_data, 32'd0);
      check("wbrst_ready", {31'd0, instr_ready}, 32'd1);
      clear_ref();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("wbrst_ready_after", {31'd0, instr_ready}, 32'd1);
      chk_dbg(5'd5);
      chk_dbg(5'd1);
      issue(enc_i(12'h123, 5'd0, 3'd6, 5'd6), 1'b1, 4'b0110);
      chk_dbg(5'd6);

      n = 0;
      while (sb_q.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("sb_drained", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
